// File: rtl/grey_counter_param.sv
// -----------------------------------------------------------------------------
// grey_counter_param
//   Parametrised Gray-code counter with enable, up/down direction, synchronous
//   clear and wrap-or-saturate behaviour. The binary and Gray registers load on
//   the same edge, so the two outputs are coherent in every cycle.
//
// Parameters:
//   WIDTH  counter width in bits (2..32)
//   WRAP   1 = modulo-2^WIDTH wrap-around, 0 = saturate at the limits
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   en          count enable (one step per cycle)
//   up          direction: 1 = increment, 0 = decrement
//   clr         synchronous clear to zero (highest synchronous priority)
//   bin_count   registered binary count
//   gray_count  registered Gray code of bin_count
//   wrap        registered event: wrapped (WRAP=1) or blocked at limit (WRAP=0)
//
// Optional build macro GREY_LOAD_EN adds:
//   load        synchronous load strobe (priority clr > load > en)
//   load_gray   Gray value to load; bin_count receives its binary equivalent
// -----------------------------------------------------------------------------
module grey_counter_param #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
`ifdef GREY_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
`endif
  output logic [WIDTH-1:0] bin_count,
  output logic [WIDTH-1:0] gray_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_limit;

`ifdef GREY_LOAD_EN
  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int unsigned i = WIDTH - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction
`endif

  always_comb begin
    bin_d    = bin_q;
    wrap_d   = 1'b0;
    at_limit = up ? (bin_q == '1) : (bin_q == '0);
    if (clr) begin
      bin_d = '0;
`ifdef GREY_LOAD_EN
    end else if (load) begin
      bin_d = gray2bin(load_gray);
`endif
    end else if (en) begin
      // Modulo arithmetic already produces the wrapped value; saturation just
      // suppresses the step. Either way the limit condition raises the flag.
      wrap_d = at_limit;
      if (at_limit && !WRAP) begin
        bin_d = bin_q;
      end else begin
        bin_d = up ? (bin_q + ONE) : (bin_q - ONE);
      end
    end
    // Gray is derived from the next binary value so both registers agree.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrap       = wrap_q;

endmodule

// File: doc/grey_counter_param.md
Name: grey_counter_param

Overview:
- Parametrised Gray-code counter, the successor to the fixed 4-bit up-only Gray counter.
- Adds:
  - configurable width
  - enable and up/down direction
  - synchronous clear
  - wrap or saturate mode
  - a registered wrap/limit event flag
- Binary and Gray outputs are registered together and are always coherent in the same cycle, with no one-cycle Gray lag.
- Used as a pointer/sequence source for CDC-safe counters elsewhere in the design.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- WRAP, 1, 1 = modulo-2^WIDTH wrap-around; 0 = saturate at all-ones (up) or zero (down).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserted low, released synchronously to clk by the system reset controller.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- clr  input  1  synchronous clear to zero; highest synchronous priority.
- bin_count  output  WIDTH  registered binary count.
- gray_count  output  WIDTH  registered Gray code of bin_count: b ^ (b >> 1).
- wrap  output  1  registered one-cycle event pulse (see Behaviour).

Behaviour:
- Reset (rst=0, asynchronous, immediate): bin_count=0, gray_count=0, wrap=0.
  - Holds while rst=0 regardless of clk or inputs.
  - Reset mid-count discards state; the first active edge after release acts on inputs normally.
- Synchronous priority per rising edge: clr > en > hold.
- clr=1: bin_count=0, gray_count=0, wrap=0, irrespective of en/up.
- en=1, clr=0:
  - up=1: next = bin_count+1.
  - up=0: next = bin_count-1.
  - Arithmetic is WIDTH bits unsigned.
- en=0, clr=0: hold both counts; wrap=0.
- Coherence invariant: at every clock edge, gray_count == bin_count ^ (bin_count >> 1).
  - Both registers load in the same edge.
  - Gray is derived from the next binary value, not the current one.
- Single-bit-change invariant: every en-step changes exactly one bit of gray_count, including across the wrap boundary.
- WRAP=1:
  - up at all-ones -> 0, with wrap=1 for one cycle.
  - down at 0 -> all-ones, with wrap=1 for one cycle.
  - wrap is asserted in the same cycle the wrapped count is visible; otherwise wrap=0.
- WRAP=0:
  - up at all-ones, or down at 0: count holds (no Gray change) and wrap=1 for that cycle, meaning "blocked at limit".
  - wrap stays high on every cycle a blocked step is requested; it is 0 on normal steps.
- Direction change takes effect on the same edge up is sampled; there is no turnaround bubble.
- Latency: input to output is 1 cycle. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: GREY_LOAD_EN.
- Defined:
  - Adds ports `load` (input, 1) and `load_gray` (input, WIDTH).
  - Priority becomes clr > load > en.
  - load=1: gray_count = load_gray, and bin_count = Gray-to-binary of load_gray (prefix XOR from MSB).
  - wrap=0 on a load cycle.
  - The single-bit-change invariant is exempt on load cycles only.
- Not defined:
  - Ports absent, no load logic.
  - Behaviour exactly as above.

Test Plan:
- Reset: rst=0 with en=1 for 3 cycles, release -> bin=0, gray=0, wrap=0; first enabled up edge gives bin=1, gray=4'b0001.
- Full up sequence, WIDTH=4, WRAP=1, en=1, up=1, 16 cycles:
  - gray follows 0000,0001,0011,0010,0110,...,1000, then 0000.
  - wrap=1 only on the cycle the count returns to 0.
  - Exactly one Gray bit changes per step.
- Down wrap, WRAP=1: from 0 with up=0 -> bin=15, gray=4'b1000, wrap=1; next step bin=14, gray=4'b1001, wrap=0.
- Saturate, WRAP=0:
  - Count up to 15, hold en=1 up=1 for 3 more cycles -> bin stays 15, gray stays 1000, wrap=1 on all 3.
  - Then up=0 -> bin=14, wrap=0.
- Priority: bin=9 with clr=1, en=1, up=1 -> bin=0, gray=0, wrap=0. With en=0 the count holds at its value for N cycles.
- GREY_LOAD_EN: load=1, load_gray=4'b1101 with en=1 -> gray=1101, bin=9; next en up step -> bin=10, gray=1111.
